// File: rtl/instr_mem_fetch.sv
// instr_mem_fetch: multi-word instruction fetch memory with registered, backpressure-holding response.
// Optional INSTR_MEM_STATS_EN adds Stat_fetches / Stat_stalls counters.
module instr_mem_fetch #(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned DEPTH       = 1 << ADDR_BITS,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned FETCH_WORDS = 2
) (
  input  logic                              Clock,
  input  logic                              Reset_n,
  input  logic                              Req_valid,
  output logic                              Req_ready,
  input  logic [ADDR_BITS-1:0]              Req_addr,
  output logic                              Resp_valid,
  input  logic                              Resp_ready,
  output logic [FETCH_WORDS*DATA_WIDTH-1:0] Resp_data,
  output logic [FETCH_WORDS-1:0]            Resp_fault,
  input  logic                              WriteEnable,
  input  logic [ADDR_BITS-1:0]              Write_addr,
  input  logic [DATA_WIDTH/8-1:0]           Write_strb,
`ifdef INSTR_MEM_STATS_EN
  input  logic [DATA_WIDTH-1:0]             Data_in,
  output logic [31:0]                       Stat_fetches,
  output logic [31:0]                       Stat_stalls
`else
  input  logic [DATA_WIDTH-1:0]             Data_in
`endif
);
  localparam int unsigned NB = DATA_WIDTH / 8;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [FETCH_WORDS*DATA_WIDTH-1:0] rd_data;
  logic [FETCH_WORDS-1:0] rd_fault;
  logic wr_ok, accept;
  assign wr_ok = WriteEnable && (32'(Write_addr) < DEPTH);
  assign Req_ready = !Resp_valid || Resp_ready;
  assign accept = Req_valid && Req_ready;
  always_ff @(posedge Clock)
    if (wr_ok)
      for (int b = 0; b < NB; b++)
        if (Write_strb[b]) mem[Write_addr][b*8 +: 8] <= Data_in[b*8 +: 8];
  genvar k;
  for (k = 0; k < FETCH_WORDS; k++) begin : g_word
    logic [ADDR_BITS-1:0] a;
    logic hit, coll;
    logic [DATA_WIDTH-1:0] w;
    assign a = Req_addr + ADDR_BITS'(k);
    assign hit = 32'(a) < DEPTH;
    assign coll = wr_ok && (Write_addr == a);
    // same-cycle write bytes bypass the array so the fetch sees write-first data
    always_comb begin
      w = hit ? mem[a] : '0;
      for (int b = 0; b < NB; b++)
        if (coll && Write_strb[b]) w[b*8 +: 8] = Data_in[b*8 +: 8];
    end
    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w;
    assign rd_fault[k] = !hit;
  end
  always_ff @(posedge Clock)
    if (!Reset_n) begin
      Resp_valid <= 1'b0;
      Resp_data  <= '0;
      Resp_fault <= '0;
    end else if (accept) begin
      Resp_valid <= 1'b1;
      Resp_data  <= rd_data;
      Resp_fault <= rd_fault;
    end else if (Resp_ready) begin
      Resp_valid <= 1'b0;
    end
`ifdef INSTR_MEM_STATS_EN
  always_ff @(posedge Clock)
    if (!Reset_n) begin
      Stat_fetches <= '0;
      Stat_stalls  <= '0;
    end else begin
      Stat_fetches <= Stat_fetches + 32'(accept);
      Stat_stalls  <= Stat_stalls + 32'(Resp_valid && !Resp_ready);
    end
`endif
endmodule

// File: tb/tb_instr_mem_fetch.sv
// tb_instr_mem_fetch: directed bench for instr_mem_fetch at DEPTH 256 and DEPTH 200,
// checked every cycle against a behavioural memory/response model plus literal expectations.
module tb_instr_mem_fetch;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n, req_valid, resp_ready, we;
  logic [7:0] req_addr, waddr;
  logic [3:0] wstrb;
  logic [31:0] wdata;
  logic rr [2];
  logic rv [2];
  logic [63:0] rd [2];
  logic [1:0] rf [2];
`ifdef INSTR_MEM_STATS_EN
  logic [31:0] sf, ss, sf1, ss1;
`endif
  instr_mem_fetch #(.ADDR_BITS(8), .DEPTH(256), .DATA_WIDTH(32), .FETCH_WORDS(2)) u0 (
    .Clock(clk), .Reset_n(rst_n), .Req_valid(req_valid), .Req_ready(rr[0]), .Req_addr(req_addr),
    .Resp_valid(rv[0]), .Resp_ready(resp_ready), .Resp_data(rd[0]), .Resp_fault(rf[0]),
    .WriteEnable(we), .Write_addr(waddr), .Write_strb(wstrb),
`ifdef INSTR_MEM_STATS_EN
    .Data_in(wdata), .Stat_fetches(sf), .Stat_stalls(ss)
`else
    .Data_in(wdata)
`endif
  );
  instr_mem_fetch #(.ADDR_BITS(8), .DEPTH(200), .DATA_WIDTH(32), .FETCH_WORDS(2)) u1 (
    .Clock(clk), .Reset_n(rst_n), .Req_valid(req_valid), .Req_ready(rr[1]), .Req_addr(req_addr),
    .Resp_valid(rv[1]), .Resp_ready(resp_ready), .Resp_data(rd[1]), .Resp_fault(rf[1]),
    .WriteEnable(we), .Write_addr(waddr), .Write_strb(wstrb),
`ifdef INSTR_MEM_STATS_EN
    .Data_in(wdata), .Stat_fetches(sf1), .Stat_stalls(ss1)
`else
    .Data_in(wdata)
`endif
  );
  int checks = 0, errors = 0;
  bit armed = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
    end
  endtask
  // model: an array per instance, and the response a consumer should currently see
  logic [31:0] m [2][256];
  bit ev [2] = '{0, 0};
  logic [63:0] ed [2] = '{64'd0, 64'd0};
  logic [1:0] ef [2] = '{2'd0, 2'd0};
  int unsigned dep [2] = '{256, 200};
  int unsigned mf = 0, ms = 0;
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit acc, stall;
      acc = rst_n && req_valid && (!ev[i] || resp_ready);
      stall = rst_n && ev[i] && !resp_ready;
      if (i == 0) begin
        mf = rst_n ? mf + 32'(acc) : 0;
        ms = rst_n ? ms + 32'(stall) : 0;
      end
      if (we && waddr < dep[i])
        for (int b = 0; b < 4; b++) if (wstrb[b]) m[i][waddr][b*8 +: 8] = wdata[b*8 +: 8];
      if (!rst_n) begin
        ev[i] = 0; ed[i] = '0; ef[i] = '0;
      end else if (acc) begin
        for (int k = 0; k < 2; k++) begin
          logic [7:0] a;
          a = req_addr + 8'(k);
          ed[i][k*32 +: 32] = (a < dep[i]) ? m[i][a] : 32'd0;
          ef[i][k] = !(a < dep[i]);
        end
        ev[i] = 1;
      end else if (resp_ready) ev[i] = 0;
    end
  end
  always @(negedge clk) if (armed) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("req_ready[%0d]", i), 64'(rr[i]), 64'(!ev[i] || resp_ready));
      chk($sformatf("resp_valid[%0d]", i), 64'(rv[i]), 64'(ev[i]));
      if (ev[i]) begin
        chk($sformatf("resp_data[%0d]", i), rd[i], ed[i]);
        chk($sformatf("resp_fault[%0d]", i), 64'(rf[i]), 64'(ef[i]));
      end
    end
`ifdef INSTR_MEM_STATS_EN
    chk("stat_fetches", 64'(sf), 64'(mf));
    chk("stat_stalls", 64'(ss), 64'(ms));
`endif
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    we = 1; waddr = a; wdata = d; wstrb = s;
  endtask
  initial begin
    rst_n = 0; req_valid = 0; req_addr = 0; resp_ready = 1;
    we = 0; waddr = 0; wstrb = 0; wdata = 0;
    tick; armed = 1; tick;
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", 64'(rv[i]), 64'd0);
      chk("rst_data", rd[i], 64'd0);
      chk("rst_fault", 64'(rf[i]), 64'd0);
      chk("rst_ready", 64'(rr[i]), 64'd1);
    end
    rst_n = 1;
    for (int a = 0; a < 256; a++) begin
      wr(8'(a), 32'hC0DE0000 | 32'(a), 4'hF); tick;
    end
    wr(8'd4, 32'h11111111, 4'hF); tick;
    wr(8'd5, 32'h22222222, 4'hF); tick;
    we = 0; req_valid = 1; req_addr = 8'd4; tick;
    req_valid = 0;
    chk("wf_data", rd[0], 64'h22222222_11111111);
    chk("wf_fault", 64'(rf[0]), 64'd0);
    tick;
    wr(8'd4, 32'hAABBCCDD, 4'b0101); tick;
    we = 0; req_valid = 1; req_addr = 8'd4; tick;
    req_valid = 0;
    chk("strb_word0", 64'(rd[0][31:0]), 64'h11BB11DD);
    tick;
    resp_ready = 0; req_valid = 1; req_addr = 8'd10; tick;
    chk("bp_ready", 64'(rr[0]), 64'd0);
    req_addr = 8'd12; wr(8'd10, 32'h55555555, 4'hF); tick;
    we = 0; tick; tick;
    chk("bp_valid", 64'(rv[0]), 64'd1);
    chk("bp_hold", rd[0], 64'hC0DE000B_C0DE000A);
    resp_ready = 1; tick;
    chk("bp_next", rd[0], 64'hC0DE000D_C0DE000C);
    req_addr = 8'd10; tick;
    req_valid = 0;
    chk("bp_written", 64'(rd[0][31:0]), 64'h55555555);
    tick;
    req_valid = 1; req_addr = 8'd199; tick;
    chk("wrap_d200_data", rd[1], 64'h00000000_C0DE00C7);
    chk("wrap_d200_fault", 64'(rf[1]), 64'b10);
    chk("wrap_d256_fault", 64'(rf[0]), 64'b00);
    req_addr = 8'd255; tick;
    chk("wrap_d256_data", rd[0], 64'hC0DE0000_C0DE00FF);
    chk("wrap_d200_f255", 64'(rf[1]), 64'b01);
    req_addr = 8'd8; wr(8'd8, 32'hDEADBEEF, 4'hF); tick;
    chk("coll_full", rd[0], 64'hC0DE0009_DEADBEEF);
    wr(8'd9, 32'h12345678, 4'b0011); tick;
    chk("coll_strb", 64'(rd[0][63:32]), 64'hC0DE5678);
    req_valid = 0; wr(8'd220, 32'h00000099, 4'hF); tick;
    we = 0; req_valid = 1; req_addr = 8'd220; tick;
    chk("oor_d200_data", rd[1], 64'd0);
    chk("oor_d200_fault", 64'(rf[1]), 64'b11);
    chk("oor_d256_data", 64'(rd[0][31:0]), 64'h99);
    req_addr = 8'd20; resp_ready = 0; tick;
    rst_n = 0; req_valid = 0; wr(8'd3, 32'h33333333, 4'hF); tick;
    chk("rmid_valid", 64'(rv[0]), 64'd0);
    chk("rmid_data", rd[0], 64'd0);
    rst_n = 1; we = 0; resp_ready = 1; req_valid = 1; req_addr = 8'd3; tick;
    chk("rmid_write", 64'(rd[0][31:0]), 64'h33333333);
    for (int n = 0; n < 60; n++) begin
      req_valid = 1'($urandom_range(0, 3) != 0);
      resp_ready = 1'($urandom_range(0, 2) != 0);
      req_addr = 8'($urandom_range(0, 255));
      we = 1'($urandom_range(0, 1));
      waddr = $urandom_range(0, 3) == 0 ? req_addr : 8'($urandom_range(0, 255));
      wstrb = 4'($urandom_range(0, 15));
      wdata = $urandom;
      tick;
    end
    req_valid = 0; we = 0; resp_ready = 1; tick; tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
Parametrised, single-clock instruction memory for the CPU fetch stage. It returns FETCH_WORDS consecutive instruction words per request over a valid/ready handshake, with a registered response stage that holds under backpressure. A byte-strobed write port is used for program loading and self-modifying code. Out-of-range words are flagged rather than returned as X.

Parameters:
ADDR_BITS, 8, word-address width; the address space is 2^ADDR_BITS words.
DEPTH, 1<<ADDR_BITS, number of implemented words; must be <= 2^ADDR_BITS.
DATA_WIDTH, 32, bits per word; must be a multiple of 8.
FETCH_WORDS, 2, words returned per fetch; must be a power of 2, from 1 to 8.

Ports:
Clock  in  1  rising-edge clock.
Reset_n  in  1  synchronous active-low reset.
Req_valid  in  1  fetch request valid.
Req_ready  out  1  fetch request can be accepted.
Req_addr  in  ADDR_BITS  word address of the first fetched word; no alignment required.
Resp_valid  out  1  response valid.
Resp_ready  in  1  consumer accepts the response.
Resp_data  out  FETCH_WORDS*DATA_WIDTH  fetched words; word k is in bits [k*DATA_WIDTH +: DATA_WIDTH].
Resp_fault  out  FETCH_WORDS  bit k set when word k's address is >= DEPTH.
WriteEnable  in  1  write request.
Write_addr  in  ADDR_BITS  write word address.
Write_strb  in  DATA_WIDTH/8  per-byte write enables.
Data_in  in  DATA_WIDTH  write data.

Behaviour:
- All state changes on the rising edge of Clock. Reset is synchronous, Reset_n = 0 at the edge.
- Reset values: Resp_valid = 0, Resp_data = 0, Resp_fault = 0. Memory contents are not altered by reset.
- Req_ready = !Resp_valid || Resp_ready. This is combinational, with no dependency on Req_valid.
- A request is accepted at the edge where Req_valid && Req_ready.
- Fixed latency of 1: at the edge after acceptance, Resp_valid = 1 and Resp_data/Resp_fault hold the result.
- Back-to-back requests sustain 1 fetch per cycle while Resp_ready = 1.
- Response hand-off happens at the edge where Resp_valid && Resp_ready. If no new request is accepted at that same edge, Resp_valid goes to 0; Resp_data keeps its old value, which is don't-care to consumers.
- Backpressure: while Resp_valid && !Resp_ready, Resp_data and Resp_fault are held bit-stable. Writes to the array during this time do not modify the held response.
- Word k address = (Req_addr + k) mod 2^ADDR_BITS, so the fetch window wraps at the top of the address space.
- If a word address is >= DEPTH: that word returns all zeros and Resp_fault[k] = 1. Other words in the same fetch are unaffected.
- Write: when WriteEnable = 1 and Write_addr < DEPTH, byte b of the word is updated from Data_in where Write_strb[b] = 1.
  - Writes to addresses >= DEPTH are dropped silently.
  - Writes are independent of the fetch handshake and are accepted every cycle.
- Read/write collision: if an accepted fetch covers Write_addr in the same cycle as a write, the response returns the merged new data (write-first, per byte strobe).
- Reset mid-operation: Reset_n = 0 discards any pending response. A write presented in the reset cycle is still performed.
- Memory contents power up undefined; no initial-load behaviour is specified.

Optional Feature:
Macro INSTR_MEM_STATS_EN.
- Defined: adds two outputs, both 32-bit wrapping counters reset to 0 by Reset_n.
  - Stat_fetches (out, 32): increments on every accepted request.
  - Stat_stalls (out, 32): increments on every cycle where Resp_valid && !Resp_ready.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: hold Reset_n = 0 for 2 cycles -> Resp_valid = 0, Resp_data = 0, Resp_fault = 0, Req_ready = 1.
- Write then fetch: write 0x11111111 to address 4 and 0x22222222 to address 5 (strb 0xF); fetch addr 4 with Resp_ready = 1 -> one cycle later Resp_data = 0x22222222_11111111, Resp_fault = 0.
- Byte strobe: with address 4 = 0x11111111, write 0xAABBCCDD with strb 0b0101 -> fetch addr 4 returns word 0 = 0x11BB11DD.
- Backpressure: fetch 10, then 12, with Resp_ready = 0 for 3 cycles -> Req_ready = 0 and the response for 10 is held stable while a write to 10 occurs. On release, addr-10 data (pre-write) is handed off, then addr-12 data the next cycle.
- Wrap and fault: DEPTH = 200, fetch 199 -> word 0 is valid with fault bit 0, word 1 = 0 with Resp_fault = 0b10. DEPTH = 256, fetch 255 -> words 255 and 0, Resp_fault = 0.
- Collision and stats: write 0xDEADBEEF to addr 8 in the same cycle as fetch 8 -> word 0 = 0xDEADBEEF. With INSTR_MEM_STATS_EN, 5 fetches with 2 stall cycles -> Stat_fetches = 5, Stat_stalls = 2.
